// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Purpose:
//   Sole driver of the register file's single write port. The in-order
//   pipeline writeback always wins the port; multi-cycle mul/div results
//   that cannot be written immediately wait in a small in-order FIFO.
//   If a buffered head waits too long behind pipeline writes, a registered
//   one-cycle wb_stall asks the pipeline to leave the next slot free.
//   A hazard query (chk_addr/chk_hit) lets decode interlock on registers
//   that still have a buffered, not-yet-written result.
//
// Parameters:
//   DEPTH       mul/div result FIFO entries (power of 2, >= 2)
//   STARVE_MAX  consecutive starved cycles before wb_stall is raised (>= 1)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active-low
//   pipe_*     pipeline writeback request (valid/addr/data)
//   md_*       mul/div result handshake (valid/addr/data in, ready out)
//   chk_addr   register queried by decode
//   chk_hit    some buffered entry targets chk_addr
//   wb_stall   registered request: pipeline holds pipe_valid=0 next cycle
//   w1_*       registered regfile write port (ena/addr/data)
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_valid,
   input  logic [4:0]  pipe_addr,
   input  logic [31:0] pipe_data,
   input  logic        md_valid,
   input  logic [4:0]  md_addr,
   input  logic [31:0] md_data,
   output logic        md_ready,
   input  logic [4:0]  chk_addr,
   output logic        chk_hit,
   output logic        wb_stall,
   output logic        w1_ena,
   output logic [4:0]  w1_addr,
   output logic [31:0] w1_data
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int ST_W  = $clog2(STARVE_MAX + 1);

   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [ST_W-1:0]  STARVE_LIM = ST_W'(STARVE_MAX);

   // FIFO storage (no reset needed: only entries covered by count are used)
   logic [4:0]  fifo_addr_q [DEPTH];
   logic [31:0] fifo_data_q [DEPTH];

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic [ST_W-1:0]  starve_q, starve_d;
   logic             wb_stall_q, wb_stall_d;
   logic             w1_ena_q,  w1_ena_d;
   logic [4:0]       w1_addr_q, w1_addr_d;
   logic [31:0]      w1_data_q, w1_data_d;

   logic pipe_wr;
   logic md_acc;
   logic md_live;
   logic fifo_ne;
   logic pop;
   logic bypass;
   logic push;
   logic [ST_W-1:0] starve_inc;

   // Full means no acceptance this cycle, even if the head pops.
   assign md_ready = rst && (count_q != FULL_CNT);

   assign pipe_wr = pipe_valid && (pipe_addr != 5'd0);
   assign md_acc  = md_valid && md_ready;
   assign md_live = md_acc && (md_addr != 5'd0);   // addr 0 is consumed and dropped
   assign fifo_ne = (count_q != '0);
   assign pop     = !pipe_wr && fifo_ne;
   assign bypass  = !pipe_wr && !fifo_ne && md_live;
   assign push    = md_live && !bypass;

   assign starve_inc = starve_q + 1'b1;

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      starve_d   = '0;
      wb_stall_d = 1'b0;
      w1_ena_d   = 1'b0;
      w1_addr_d  = w1_addr_q;
      w1_data_d  = w1_data_q;

      // Write-port selection: pipe > FIFO head > bypassed mul/div result
      if (pipe_wr) begin
         w1_ena_d  = 1'b1;
         w1_addr_d = pipe_addr;
         w1_data_d = pipe_data;
      end else if (fifo_ne) begin
         w1_ena_d  = 1'b1;
         w1_addr_d = fifo_addr_q[rd_ptr_q];
         w1_data_d = fifo_data_q[rd_ptr_q];
      end else if (bypass) begin
         w1_ena_d  = 1'b1;
         w1_addr_d = md_addr;
         w1_data_d = md_data;
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Starvation: only a head losing to a pipe write counts; anything
      // else (pop or empty FIFO) clears the counter.
      if (fifo_ne && pipe_wr) begin
         if (starve_inc == STARVE_LIM) begin
            wb_stall_d = 1'b1;
            starve_d   = '0;
         end else begin
            starve_d   = starve_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         starve_q   <= '0;
         wb_stall_q <= 1'b0;
         w1_ena_q   <= 1'b0;
         w1_addr_q  <= '0;
         w1_data_q  <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         starve_q   <= starve_d;
         wb_stall_q <= wb_stall_d;
         w1_ena_q   <= w1_ena_d;
         w1_addr_q  <= w1_addr_d;
         w1_data_q  <= w1_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= md_addr;
         fifo_data_q[wr_ptr_q] <= md_data;
      end
   end

   // Hazard query: an entry is live when its distance from the read
   // pointer is below the occupancy count.
   logic [DEPTH-1:0] hit_vec;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      logic [PTR_W-1:0] off;
      assign off         = PTR_W'(gi) - rd_ptr_q;
      assign hit_vec[gi] = ({1'b0, off} < count_q) && (fifo_addr_q[gi] == chk_addr);
   end

   assign chk_hit  = (chk_addr != 5'd0) && (|hit_vec);
   assign wb_stall = wb_stall_q;
   assign w1_ena   = w1_ena_q;
   assign w1_addr  = w1_addr_q;
   assign w1_data  = w1_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pipe_valid = 1'b0;
   logic [4:0]  pipe_addr  = '0;
   logic [31:0] pipe_data  = '0;
   logic        md_valid   = 1'b0;
   logic [4:0]  md_addr    = '0;
   logic [31:0] md_data    = '0;
   logic        md_ready;
   logic [4:0]  chk_addr   = '0;
   logic        chk_hit;
   logic        wb_stall;
   logic        w1_ena;
   logic [4:0]  w1_addr;
   logic [31:0] w1_data;

   wb_port_arbiter #(
      .DEPTH(DEPTH),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pipe_valid(pipe_valid),
      .pipe_addr(pipe_addr),
      .pipe_data(pipe_data),
      .md_valid(md_valid),
      .md_addr(md_addr),
      .md_data(md_data),
      .md_ready(md_ready),
      .chk_addr(chk_addr),
      .chk_hit(chk_hit),
      .wb_stall(wb_stall),
      .w1_ena(w1_ena),
      .w1_addr(w1_addr),
      .w1_data(w1_data)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        mq[$];
   int          m_starve = 0;
   logic        m_ena    = 1'b0;
   logic [4:0]  m_addr   = '0;
   logic [31:0] m_data   = '0;
   logic        m_stall  = 1'b0;

   initial begin : model
      bit   pw, acc, had;
      ent_t e;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            mq.delete();
            m_starve = 0;
            m_ena    = 1'b0;
            m_addr   = '0;
            m_data   = '0;
            m_stall  = 1'b0;
         end else begin
            pw  = pipe_valid && (pipe_addr != 0);
            acc = md_valid && (mq.size() != DEPTH) && (md_addr != 0);
            had = (mq.size() != 0);
            m_ena   = 1'b0;
            m_stall = 1'b0;
            if (pw) begin
               m_ena = 1'b1; m_addr = pipe_addr; m_data = pipe_data;
            end else if (had) begin
               e = mq.pop_front();
               m_ena = 1'b1; m_addr = e.a; m_data = e.d;
            end else if (acc) begin
               m_ena = 1'b1; m_addr = md_addr; m_data = md_data;
               acc = 1'b0;
            end
            if (acc) begin
               e.a = md_addr; e.d = md_data;
               mq.push_back(e);
            end
            if (pw && had) begin
               m_starve++;
               if (m_starve == STARVE_MAX) begin
                  m_stall  = 1'b1;
                  m_starve = 0;
               end
            end else begin
               m_starve = 0;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin : compare
      logic exp_hit;
      logic exp_ready;
      forever begin
         @(posedge clk);
         #1;
         exp_ready = rst && (mq.size() != DEPTH);
         exp_hit   = 1'b0;
         foreach (mq[i]) if (chk_addr != 0 && mq[i].a == chk_addr) exp_hit = 1'b1;
         chk("cyc_w1_ena", 32'(w1_ena), 32'(m_ena));
         chk("cyc_w1_addr", 32'(w1_addr), 32'(m_addr));
         chk("cyc_w1_data", w1_data, m_data);
         chk("cyc_wb_stall", 32'(wb_stall), 32'(m_stall));
         chk("cyc_md_ready", 32'(md_ready), 32'(exp_ready));
         chk("cyc_chk_hit", 32'(chk_hit), 32'(exp_hit));
         if (w1_ena) $display("[TB] t=%0t write x%0d <= %h", $time, w1_addr, w1_data);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic drive(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                        input logic mv, input logic [4:0] ma, input logic [31:0] mdd);
      @(negedge clk);
      pipe_valid = pv; pipe_addr = pa; pipe_data = pd;
      md_valid   = mv; md_addr   = ma; md_data   = mdd;
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   initial begin : stim
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_w1_ena", 32'(w1_ena), 32'd0);
      chk("rst_w1_addr", 32'(w1_addr), 32'd0);
      chk("rst_w1_data", w1_data, 32'd0);
      chk("rst_wb_stall", 32'(wb_stall), 32'd0);
      chk("rst_md_ready", 32'(md_ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // pipe write, then idle
      drive(1, 5, 32'h1234, 0, 0, 0);
      settle();
      chk("pipe_ena", 32'(w1_ena), 32'd1);
      chk("pipe_addr", 32'(w1_addr), 32'd5);
      chk("pipe_data", w1_data, 32'h1234);
      drive(0, 0, 0, 0, 0, 0);
      settle();
      chk("idle_ena", 32'(w1_ena), 32'd0);
      chk("idle_addr_hold", 32'(w1_addr), 32'd5);

      // bypass of md result into empty FIFO
      drive(0, 0, 0, 1, 7, 32'hDEAD);
      chk_addr = 5'd7;
      #1;
      chk("byp_ready_pre", 32'(md_ready), 32'd1);
      chk("byp_hit_pre", 32'(chk_hit), 32'd0);
      settle();
      chk("byp_addr", 32'(w1_addr), 32'd7);
      chk("byp_data", w1_data, 32'hDEAD);
      chk("byp_hit_post", 32'(chk_hit), 32'd0);
      chk("byp_ready_post", 32'(md_ready), 32'd1);

      // starvation: pipe writes every cycle while md offers addr 3 then 4
      for (int k = 0; k < 5; k++) begin
         drive(1, 5'(k + 1), 32'h100 + 32'(k), (k < 2), (k == 0) ? 5'd3 : 5'd4,
               (k == 0) ? 32'h333 : 32'h444);
         if (k == 2) begin
            chk_addr = 5'd3;
            #1;
            chk("full_ready", 32'(md_ready), 32'd0);
            chk("full_hit3", 32'(chk_hit), 32'd1);
            chk_addr = 5'd4;
            #1;
            chk("full_hit4", 32'(chk_hit), 32'd1);
         end
         settle();
         if (k == 3) chk("starve_no_stall", 32'(wb_stall), 32'd0);
         if (k == 4) chk("starve_stall", 32'(wb_stall), 32'd1);
      end
      drive(0, 0, 0, 0, 0, 0);
      settle();
      chk("drain3_addr", 32'(w1_addr), 32'd3);
      chk("drain3_data", w1_data, 32'h333);
      chk("drain3_stall", 32'(wb_stall), 32'd0);
      drive(0, 0, 0, 0, 0, 0);
      settle();
      chk("drain4_addr", 32'(w1_addr), 32'd4);
      chk("drain4_data", w1_data, 32'h444);
      chk("drain4_ready", 32'(md_ready), 32'd1);

      // simultaneous pop and push
      drive(1, 1, 32'h11, 1, 9, 32'h999);
      settle();
      drive(0, 0, 0, 1, 10, 32'hAAA);
      settle();
      chk("pp_addr", 32'(w1_addr), 32'd9);
      chk("pp_data", w1_data, 32'h999);
      chk("pp_ready", 32'(md_ready), 32'd1);
      chk_addr = 5'd10;
      #1;
      chk("pp_hit10", 32'(chk_hit), 32'd1);
      drive(0, 0, 0, 0, 0, 0);
      settle();
      chk("pp_pop10", 32'(w1_addr), 32'd10);
      chk("pp_pop10_data", w1_data, 32'hAAA);

      // address-0 writes are dropped
      drive(0, 0, 0, 1, 0, 32'h55);
      #1;
      chk("z_ready", 32'(md_ready), 32'd1);
      settle();
      chk("z_md_ena", 32'(w1_ena), 32'd0);
      chk("z_md_ready_post", 32'(md_ready), 32'd1);
      drive(1, 0, 32'h66, 0, 0, 0);
      settle();
      chk("z_pipe_ena", 32'(w1_ena), 32'd0);
      chk("z_addr_hold", 32'(w1_addr), 32'd10);

      // reset mid-operation with two buffered entries
      drive(1, 1, 32'h1, 1, 11, 32'hB1);
      drive(1, 2, 32'h2, 1, 12, 32'hB2);
      drive(0, 0, 0, 0, 0, 0);
      chk_addr = 5'd12;
      #1;
      chk("mr_hit12", 32'(chk_hit), 32'd1);
      chk("mr_ready", 32'(md_ready), 32'd0);
      #2 rst = 1'b0;
      #1;
      chk("mr_ena_now", 32'(w1_ena), 32'd0);
      chk("mr_ready_rst", 32'(md_ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      chk_addr = 5'd11;
      #1;
      chk("mr_hit11_after", 32'(chk_hit), 32'd0);
      chk("mr_ready_after", 32'(md_ready), 32'd1);
      chk_addr = 5'd12;
      #1;
      chk("mr_hit12_after", 32'(chk_hit), 32'd0);
      for (int k = 0; k < 4; k++) begin
         settle();
         chk("mr_no_write", 32'(w1_ena), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
